// File: rtl/disp_hex_scan_pkg.sv
// rtl/disp_hex_scan_pkg.sv - shared constants for the four-digit hex display scanner
// Contents: digit count, active-low segment table (a at bit 6, g at bit 0),
// all-segments-off and all-anodes-off constants.
package disp_hex_scan_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Index 0 is the first element of the concatenation.
  localparam logic [0:15][6:0] SEG_TABLE = {
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/hex_to_sseg.sv
// rtl/hex_to_sseg.sv - 4-bit hex to 7-segment active-low decoder
// Ports: i_hex  - hex digit in
//        o_seg  - segments a..g, active-low, a at bit 6
module hex_to_sseg
  import disp_hex_scan_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_hex];

endmodule

// File: rtl/disp_hex_scan.sv
// rtl/disp_hex_scan.sv - time-multiplexed four-digit hex display scanner
// Ports: clk        - system clock, rising edge
//        reset      - synchronous active-high reset
//        load       - strobe sampling hex_in/dp_in into the shadow register
//        hex_in     - four hex digits, digit 0 in bits [3:0]
//        dp_in      - decimal point per digit, 1 = lit
//        an         - digit enables, active-low
//        sseg       - segments, active-low, sseg[7] = dp, a at bit 6
//        digit_tick - one-clock pulse per slot advance
// Option: DISP_LZB_EN enables leading-zero blanking.
module disp_hex_scan
  import disp_hex_scan_pkg::*;
#(
  parameter int SCAN_BITS = 18,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [15:0]           hex_in,
  input  logic [3:0]            dp_in,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            sseg,
  output logic                  digit_tick
);

  logic [SCAN_BITS-1:0]  r_presc;
  logic [1:0]            r_idx;
  logic [15:0]           r_shadow_hex;
  logic [3:0]            r_shadow_dp;
  logic [15:0]           r_disp_hex;
  logic [3:0]            r_disp_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic [7:0]            r_sseg;
  logic                  r_tick;

  logic                  w_wrap;
  logic                  w_frame;
  logic                  w_blank;
  logic [3:0]            w_sel_hex;
  logic                  w_sel_dp;
  logic [6:0]            w_dec_seg;
  logic [6:0]            w_seg;
  logic [NUM_DIGITS-1:0] w_an_next;

  assign w_wrap  = &r_presc;
  // The frame boundary is the tick that takes the slot index from 3 back to 0.
  assign w_frame = w_wrap & (r_idx == 2'd3);

  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign w_blank = 1'b0;
    end else begin : g_blank
      localparam logic [SCAN_BITS-1:0] BLANK_W = SCAN_BITS'(BLANK_CYC);
      assign w_blank = (r_presc < BLANK_W);
    end
  endgenerate

  always_comb begin
    w_sel_hex = r_disp_hex[3:0];
    case (r_idx)
      2'd0:    w_sel_hex = r_disp_hex[3:0];
      2'd1:    w_sel_hex = r_disp_hex[7:4];
      2'd2:    w_sel_hex = r_disp_hex[11:8];
      default: w_sel_hex = r_disp_hex[15:12];
    endcase
  end

  assign w_sel_dp = r_disp_dp[r_idx];

  hex_to_sseg u_dec (
    .i_hex (w_sel_hex),
    .o_seg (w_dec_seg)
  );

`ifdef DISP_LZB_EN
  // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
  logic [3:0] w_lzb_mask;
  assign w_lzb_mask[3] = (r_disp_hex[15:12] == 4'h0);
  assign w_lzb_mask[2] = w_lzb_mask[3] & (r_disp_hex[11:8] == 4'h0);
  assign w_lzb_mask[1] = w_lzb_mask[2] & (r_disp_hex[7:4] == 4'h0);
  assign w_lzb_mask[0] = 1'b0;
  assign w_seg = w_lzb_mask[r_idx] ? SEG_OFF : w_dec_seg;
`else
  assign w_seg = w_dec_seg;
`endif

  assign w_an_next = w_blank ? AN_OFF : ~(4'b0001 << r_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc      <= '0;
      r_idx        <= 2'd0;
      r_shadow_hex <= 16'h0000;
      r_shadow_dp  <= 4'h0;
      r_disp_hex   <= 16'h0000;
      r_disp_dp    <= 4'h0;
      r_an         <= AN_OFF;
      r_sseg       <= 8'hFF;
      r_tick       <= 1'b0;
    end else begin
      r_presc <= r_presc + 1'b1;
      r_tick  <= w_wrap;
      if (w_wrap) begin
        r_idx <= r_idx + 2'd1;
      end
      // A load landing on the boundary bypasses the shadow so it shows this frame.
      if (w_frame) begin
        r_disp_hex <= load ? hex_in : r_shadow_hex;
        r_disp_dp  <= load ? dp_in  : r_shadow_dp;
      end
      if (load) begin
        r_shadow_hex <= hex_in;
        r_shadow_dp  <= dp_in;
      end
      r_an   <= w_an_next;
      r_sseg <= {~w_sel_dp, w_seg};
    end
  end

  assign an         = r_an;
  assign sseg       = r_sseg;
  assign digit_tick = r_tick;

endmodule

// File: tb/tb_disp_hex_scan.sv
// tb/tb_disp_hex_scan.sv - self-checking bench for disp_hex_scan
module tb_disp_hex_scan;

  localparam int SB    = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = 1 << SB;

`ifdef DISP_LZB_EN
  localparam logic [7:0] Z_SSEG = 8'hFF;
`else
  localparam logic [7:0] Z_SSEG = 8'h81;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] hex_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        digit_tick;

  disp_hex_scan #(.SCAN_BITS(SB), .BLANK_CYC(BLANK)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .an         (an),
    .sseg       (sseg),
    .digit_tick (digit_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] pat [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int n_vec = 0;
  int n_err = 0;
  int ecnt  = 0;

  // Reference model: cycle count since reset gives slot and position directly.
  int          m_cnt = 0;
  logic [15:0] m_sh_h = 0, m_dis_h = 0;
  logic [3:0]  m_sh_d = 0, m_dis_d = 0;
  logic [3:0]  e_an;
  logic [7:0]  e_sseg;
  logic        e_tick;

  task automatic model_edge(input bit rst, input bit ld, input logic [15:0] hx, input logic [3:0] dpv);
    int pr, sl, hi;
    logic [3:0] dig, onehot;
    logic [6:0] seg7;
    if (rst) begin
      m_cnt = 0; m_sh_h = 0; m_sh_d = 0; m_dis_h = 0; m_dis_d = 0;
      e_an = 4'hF; e_sseg = 8'hFF; e_tick = 1'b0;
    end else begin
      pr = m_cnt % SLOT;
      sl = (m_cnt / SLOT) % 4;
      onehot = 4'b0001 << sl;
      e_an = (pr < BLANK) ? 4'hF : ~onehot;
      dig = 4'((m_dis_h >> (4 * sl)) & 16'hF);
      seg7 = pat[dig];
`ifdef DISP_LZB_EN
      hi = 0;
      for (int i = 0; i < 4; i++)
        if (((m_dis_h >> (4 * i)) & 16'hF) != 0) hi = i;
      if (sl > hi) seg7 = 7'h7F;
`else
      hi = 0;
`endif
      e_sseg = {~m_dis_d[sl], seg7};
      e_tick = (pr == SLOT - 1);
      if (pr == SLOT - 1 && sl == 3) begin
        m_dis_h = ld ? hx : m_sh_h;
        m_dis_d = ld ? dpv : m_sh_d;
      end
      if (ld) begin
        m_sh_h = hx; m_sh_d = dpv;
      end
      m_cnt++;
    end
  endtask

  task automatic check(input string name, input logic [3:0] x_an, input logic [7:0] x_sseg, input logic x_tick);
    n_vec++;
    if (an !== x_an || sseg !== x_sseg || digit_tick !== x_tick) begin
      n_err++;
      $display("FAIL %s: got an=%b sseg=%h tick=%b, expected an=%b sseg=%h tick=%b",
               name, an, sseg, digit_tick, x_an, x_sseg, x_tick);
    end
  endtask

  task automatic step(input bit rst, input bit ld, input logic [15:0] hx, input logic [3:0] dpv);
    reset = rst; load = ld; hex_in = hx; dp_in = dpv;
    @(posedge clk);
    model_edge(rst, ld, hx, dpv);
    #1;
    check($sformatf("model t=%0t", $time), e_an, e_sseg, e_tick);
    reset = 1'b0; load = 1'b0;
    if (rst) ecnt = 0; else ecnt++;
  endtask

  typedef struct {
    int          at;
    bit          rst;
    bit          ld;
    logic [15:0] hx;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        tick;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int at, bit rst, bit ld, logic [15:0] hx, logic [3:0] dp,
                              logic [3:0] xa, logic [7:0] xs, logic xt);
    vec_t v;
    v.at = at; v.rst = rst; v.ld = ld; v.hx = hx; v.dp = dp;
    v.an = xa; v.sseg = xs; v.tick = xt;
    return v;
  endfunction

  initial begin
    // Scan of 1234 with dp on digit 0.
    tbl.push_back(mk(  1, 0, 1, 16'h1234, 4'b0001, 4'b1111, 8'h81, 1'b0));
    tbl.push_back(mk( 16, 0, 0, 16'h0,    4'h0,    4'b1110, 8'h81, 1'b1));
    tbl.push_back(mk( 17, 0, 0, 16'h0,    4'h0,    4'b1111, 8'h81, 1'b0));
    tbl.push_back(mk( 19, 0, 0, 16'h0,    4'h0,    4'b1101, 8'h81, 1'b0));
    tbl.push_back(mk( 60, 0, 0, 16'h0,    4'h0,    4'b0111, 8'h81, 1'b0));
    tbl.push_back(mk( 65, 0, 0, 16'h0,    4'h0,    4'b1111, 8'h4C, 1'b0));
    tbl.push_back(mk( 67, 0, 0, 16'h0,    4'h0,    4'b1110, 8'h4C, 1'b0));
    tbl.push_back(mk( 83, 0, 0, 16'h0,    4'h0,    4'b1101, 8'h86, 1'b0));
    tbl.push_back(mk( 99, 0, 0, 16'h0,    4'h0,    4'b1011, 8'h92, 1'b0));
    tbl.push_back(mk(115, 0, 0, 16'h0,    4'h0,    4'b0111, 8'hCF, 1'b0));
    // Mid-frame load of ABCD is deferred to the next boundary.
    tbl.push_back(mk(150, 0, 1, 16'hABCD, 4'b0000, 4'b1101, 8'h86, 1'b0));
    tbl.push_back(mk(179, 0, 0, 16'h0,    4'h0,    4'b0111, 8'hCF, 1'b0));
    tbl.push_back(mk(190, 0, 0, 16'h0,    4'h0,    4'b0111, 8'hCF, 1'b0));
    tbl.push_back(mk(195, 0, 0, 16'h0,    4'h0,    4'b1110, 8'hC2, 1'b0));
    tbl.push_back(mk(211, 0, 0, 16'h0,    4'h0,    4'b1101, 8'hB1, 1'b0));
    tbl.push_back(mk(243, 0, 0, 16'h0,    4'h0,    4'b0111, 8'h88, 1'b0));
    // Load on the boundary tick bypasses straight into this frame.
    tbl.push_back(mk(256, 0, 1, 16'h5678, 4'b1000, 4'b0111, 8'h88, 1'b1));
    tbl.push_back(mk(259, 0, 0, 16'h0,    4'h0,    4'b1110, 8'h80, 1'b0));
    tbl.push_back(mk(307, 0, 0, 16'h0,    4'h0,    4'b0111, 8'h24, 1'b0));
    // Reset during the digit 2 slot, with load also asserted.
    tbl.push_back(mk(358, 1, 1, 16'hFFFF, 4'hF,    4'b1111, 8'hFF, 1'b0));
    // Scan restarts at digit 0; then leading-zero case 0070.
    tbl.push_back(mk(  1, 0, 1, 16'h0070, 4'h0,    4'b1111, 8'h81, 1'b0));
    tbl.push_back(mk(  3, 0, 0, 16'h0,    4'h0,    4'b1110, 8'h81, 1'b0));
    tbl.push_back(mk( 16, 0, 0, 16'h0,    4'h0,    4'b1110, 8'h81, 1'b1));
    tbl.push_back(mk( 67, 0, 0, 16'h0,    4'h0,    4'b1110, 8'h81, 1'b0));
    tbl.push_back(mk( 83, 0, 0, 16'h0,    4'h0,    4'b1101, 8'h8F, 1'b0));
    tbl.push_back(mk( 99, 0, 0, 16'h0,    4'h0,    4'b1011, Z_SSEG, 1'b0));
    tbl.push_back(mk(115, 0, 0, 16'h0,    4'h0,    4'b0111, Z_SSEG, 1'b0));

    // Reset held for three cycles with load active.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 16'($urandom), 4'($urandom));
      check($sformatf("reset%0d", i), 4'hF, 8'hFF, 1'b0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      while (ecnt < tbl[i].at - 1) step(1'b0, 1'b0, 16'h0, 4'h0);
      step(tbl[i].rst, tbl[i].ld, tbl[i].hx, tbl[i].dp);
      check($sformatf("vec%0d@%0d", i, tbl[i].at), tbl[i].an, tbl[i].sseg, tbl[i].tick);
    end

    // Random loads and occasional resets against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0,
           16'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
